mux_hold_bank: RTL and testbench

MUX_HOLD_BANK -- requirements
Module: mux_hold_bank

---
 rtl/mux_hold_bank.sv | 163 ++++++++++++++++
 tb/tb_mux_hold_bank.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mux_hold_bank.sv
// ---------------------------------------------------------------------------
// mux_hold_bank
//
// Purpose:
//   Registers a bank of packed input channels, a channel select and a load
//   enable.  On a load, it copies the selected channel into a held output
//   register.  The pin-to-out latency is exactly two cycles: the S1 input
//   stage, then the output register.
//   EDGE_MODE selects how loads happen:
//     0 : out follows the selected channel on every cycle that le is high.
//     1 : out captures once per rising edge of le.
//   An out-of-range select never loads.  Instead it raises sel_err.
//
// Optional feature:
//   Define MUX_HOLD_BANK_CAPCNT_EN to build the saturating capture counter.
//   Without it, cap_cnt is tied to zero and no counter flops exist.
//
// Parameters:
//   WIDTH     data bits per channel (>= 1)
//   CHANNELS  number of input channels (2..16)
//   SEL_W     select width, CHANNELS <= 2**SEL_W
//   EDGE_MODE 0 = level-enable hold, 1 = rising-edge capture
//   CNT_W     capture counter width
//
// Ports:
//   CLK      in   sole clock, rising edge
//   RSTn     in   synchronous active-low reset
//   idata    in   CHANNELS*WIDTH packed channels, channel k at [k*WIDTH +: WIDTH]
//   sel      in   channel select
//   le       in   load enable
//   out      out  held data (registered)
//   sel_err  out  last sampled select was out of range (registered)
//   upd      out  one-cycle pulse: out was loaded (registered)
//   cap_cnt  out  saturating count of loads (zero unless the counter is built)
// ---------------------------------------------------------------------------
module mux_hold_bank #(
    parameter int WIDTH     = 2,
    parameter int CHANNELS  = 3,
    parameter int SEL_W     = 2,
    parameter int EDGE_MODE = 0,
    parameter int CNT_W     = 8
) (
    input  logic                      CLK,
    input  logic                      RSTn,
    input  logic [CHANNELS*WIDTH-1:0] idata,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      le,
    output logic [WIDTH-1:0]          out,
    output logic                      sel_err,
    output logic                      upd,
    output logic [CNT_W-1:0]          cap_cnt
);

    localparam int             NSLOT  = 2 ** SEL_W;
    localparam logic [SEL_W:0] CH_LIM = (SEL_W + 1)'(CHANNELS);

    // S1 input stage
    logic [CHANNELS*WIDTH-1:0] s1_data_q, s1_data_d;
    logic [SEL_W-1:0]          s1_sel_q, s1_sel_d;
    logic                      s1_le_q, s1_le_d;
    // le as it was one cycle before the current S1 value (edge detection)
    logic                      prev_le_q, prev_le_d;
    // output stage
    logic [WIDTH-1:0]          out_q, out_d;
    logic                      sel_err_q, sel_err_d;
    logic                      upd_q, upd_d;

    logic [WIDTH-1:0]          ch_s [NSLOT];
    logic [WIDTH-1:0]          mux_s;
    logic                      sel_valid_s;
    logic                      load_s;

    // Pad unused select codes with zero, so the mux never reads outside idata
    // and never produces X.
    for (genvar g = 0; g < NSLOT; g++) begin : g_ch
        if (g < CHANNELS) begin : g_live
            assign ch_s[g] = s1_data_q[g*WIDTH +: WIDTH];
        end else begin : g_pad
            assign ch_s[g] = {WIDTH{1'b0}};
        end
    end

    // S1 samples the pins every cycle with no enable
    always_comb begin
        s1_data_d = idata;
        s1_sel_d  = sel;
        s1_le_d   = le;
    end

    // Select decode, load qualification and next output state
    always_comb begin
        mux_s       = ch_s[s1_sel_q];
        sel_valid_s = ({1'b0, s1_sel_q} < CH_LIM);
        prev_le_d   = s1_le_q;
        if (EDGE_MODE != 0) begin
            load_s = s1_le_q & ~prev_le_q;
        end else begin
            load_s = s1_le_q;
        end
        // sel_err tracks S1.sel every cycle, independent of le
        sel_err_d = ~sel_valid_s;
        if (load_s && sel_valid_s) begin
            out_d = mux_s;
            upd_d = 1'b1;
        end else begin
            out_d = out_q;
            upd_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            s1_data_q <= {(CHANNELS*WIDTH){1'b0}};
            s1_sel_q  <= {SEL_W{1'b0}};
            s1_le_q   <= 1'b0;
            prev_le_q <= 1'b0;
            out_q     <= {WIDTH{1'b0}};
            sel_err_q <= 1'b0;
            upd_q     <= 1'b0;
        end else begin
            s1_data_q <= s1_data_d;
            s1_sel_q  <= s1_sel_d;
            s1_le_q   <= s1_le_d;
            prev_le_q <= prev_le_d;
            out_q     <= out_d;
            sel_err_q <= sel_err_d;
            upd_q     <= upd_d;
        end
    end

`ifdef MUX_HOLD_BANK_CAPCNT_EN
    logic [CNT_W-1:0] cap_cnt_q, cap_cnt_d;

    // The counter steps on the same edge that raises upd, so it always
    // equals the number of upd pulses seen so far.  It stops at all-ones.
    always_comb begin
        if (upd_d && (cap_cnt_q != {CNT_W{1'b1}})) begin
            cap_cnt_d = cap_cnt_q + CNT_W'(1);
        end else begin
            cap_cnt_d = cap_cnt_q;
        end
    end

    // Capture counter register
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            cap_cnt_q <= {CNT_W{1'b0}};
        end else begin
            cap_cnt_q <= cap_cnt_d;
        end
    end

    assign cap_cnt = cap_cnt_q;
`else
    assign cap_cnt = {CNT_W{1'b0}};
`endif

    assign out     = out_q;
    assign sel_err = sel_err_q;
    assign upd     = upd_q;

endmodule

// File: tb/tb_mux_hold_bank.sv
// ---------------------------------------------------------------------------
// tb_mux_hold_bank
//
// Runs two instances of mux_hold_bank in parallel from one shared stimulus:
//   dut0: EDGE_MODE=0, CNT_W=2
//   dut1: EDGE_MODE=1, CNT_W=8
// Each step computes the expected outputs of both instances and pushes them
// into a scoreboard queue.  The bench pops and compares them two cycles
// later, which is when the design presents that vector's result.
// ---------------------------------------------------------------------------
module tb_mux_hold_bank;

`ifdef MUX_HOLD_BANK_CAPCNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RSTn;
    logic [5:0] idata;
    logic [1:0] sel;
    logic       le;

    logic [1:0] out0, out1;
    logic       err0, err1, upd0, upd1;
    logic [1:0] cnt0;
    logic [7:0] cnt1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0] out0;
        logic       upd0;
        logic [1:0] cnt0;
        logic [1:0] out1;
        logic       upd1;
        logic [7:0] cnt1;
        logic       err;
    } exp_t;

    exp_t sb[$];

    // reference model state
    logic [1:0] m_hold0, m_hold1;
    logic       m_prev1;
    logic [1:0] m_cnt0;
    logic [7:0] m_cnt1;

    mux_hold_bank #(.WIDTH(2), .CHANNELS(3), .SEL_W(2), .EDGE_MODE(0), .CNT_W(2)) dut0 (
        .CLK(CLK), .RSTn(RSTn), .idata(idata), .sel(sel), .le(le),
        .out(out0), .sel_err(err0), .upd(upd0), .cap_cnt(cnt0)
    );

    mux_hold_bank #(.WIDTH(2), .CHANNELS(3), .SEL_W(2), .EDGE_MODE(1), .CNT_W(8)) dut1 (
        .CLK(CLK), .RSTn(RSTn), .idata(idata), .sel(sel), .le(le),
        .out(out1), .sel_err(err1), .upd(upd1), .cap_cnt(cnt1)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Apply one vector, record its expected result, advance one clock, then
    // compare the result that is due after this edge.
    task automatic step(input logic rst, input logic [5:0] d, input logic [1:0] s,
                        input logic l, input string tag);
        exp_t       e;
        logic [1:0] v;
        logic       ld1;
        RSTn  = rst;
        idata = d;
        sel   = s;
        le    = l;
        e = '{default: '0};
        if (!rst) begin
            // Reset kills the vector still in flight and clears all state.
            m_hold0 = 2'd0; m_hold1 = 2'd0; m_prev1 = 1'b0;
            m_cnt0  = 2'd0; m_cnt1  = 8'd0;
            if (sb.size() > 0) sb[$] = e;
            sb.push_back(e);
        end else begin
            v = (s == 2'd0) ? d[1:0] : (s == 2'd1) ? d[3:2] : d[5:4];
            e.err = (s == 2'd3);
            ld1 = l & ~m_prev1;
            m_prev1 = l;
            if (l && (s != 2'd3)) begin
                m_hold0 = v;
                e.upd0  = 1'b1;
                if (CNT_ON && (m_cnt0 != 2'd3)) m_cnt0 = m_cnt0 + 2'd1;
            end
            if (ld1 && (s != 2'd3)) begin
                m_hold1 = v;
                e.upd1  = 1'b1;
                if (CNT_ON && (m_cnt1 != 8'hFF)) m_cnt1 = m_cnt1 + 8'd1;
            end
            e.out0 = m_hold0; e.cnt0 = m_cnt0;
            e.out1 = m_hold1; e.cnt1 = m_cnt1;
            sb.push_back(e);
        end
        @(posedge CLK);
        #1;
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            chk({tag, ".out0"}, {6'd0, out0}, {6'd0, e.out0});
            chk({tag, ".upd0"}, {7'd0, upd0}, {7'd0, e.upd0});
            chk({tag, ".err0"}, {7'd0, err0}, {7'd0, e.err});
            chk({tag, ".cnt0"}, {6'd0, cnt0}, {6'd0, e.cnt0});
            chk({tag, ".out1"}, {6'd0, out1}, {6'd0, e.out1});
            chk({tag, ".upd1"}, {7'd0, upd1}, {7'd0, e.upd1});
            chk({tag, ".err1"}, {7'd0, err1}, {7'd0, e.err});
            chk({tag, ".cnt1"}, cnt1, e.cnt1);
        end
    endtask

    initial begin
        RSTn = 1'b0; idata = 6'd0; sel = 2'd0; le = 1'b0;
        m_hold0 = 2'd0; m_hold1 = 2'd0; m_prev1 = 1'b0; m_cnt0 = 2'd0; m_cnt1 = 8'd0;

        // reset state
        step(1'b0, 6'd0, 2'd0, 1'b0, "rst");
        step(1'b0, 6'd0, 2'd0, 1'b0, "rst");

        // single le pulse, sel=1 -> out=2'b10 two cycles later, then held
        step(1'b1, 6'b11_10_01, 2'd1, 1'b1, "pulse");
        step(1'b1, 6'b00_00_00, 2'd1, 1'b0, "hold");
        step(1'b1, 6'b01_01_11, 2'd0, 1'b0, "hold");
        step(1'b1, 6'b11_11_11, 2'd2, 1'b0, "hold");

        // le held high, channel 0 toggles 0 -> 3 -> 1
        step(1'b1, 6'b11_10_00, 2'd0, 1'b1, "follow");
        step(1'b1, 6'b11_10_11, 2'd0, 1'b1, "follow");
        step(1'b1, 6'b11_10_01, 2'd0, 1'b1, "follow");
        step(1'b1, 6'b11_10_10, 2'd0, 1'b0, "follow_end");

        // le high 5 cycles on channel 2 with changing data
        step(1'b1, 6'b01_00_00, 2'd2, 1'b1, "edge");
        step(1'b1, 6'b10_00_00, 2'd2, 1'b1, "edge");
        step(1'b1, 6'b11_00_00, 2'd2, 1'b1, "edge");
        step(1'b1, 6'b00_00_00, 2'd2, 1'b1, "edge");
        step(1'b1, 6'b01_00_00, 2'd2, 1'b1, "edge");
        step(1'b1, 6'b10_10_10, 2'd2, 1'b0, "edge_end");

        // out-of-range select with le high
        step(1'b1, 6'b11_11_11, 2'd3, 1'b1, "selerr");
        step(1'b1, 6'b11_11_11, 2'd3, 1'b1, "selerr");
        step(1'b1, 6'b11_11_11, 2'd3, 1'b0, "selerr_idle");
        step(1'b1, 6'b11_11_11, 2'd0, 1'b0, "selerr_clr");

        // counter saturation: reset, then 5 separate loads
        step(1'b0, 6'd0, 2'd0, 1'b0, "cnt_rst");
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 6'(i + 5), 2'd1, 1'b1, "cnt_load");
            step(1'b1, 6'd0, 2'd0, 1'b0, "cnt_gap");
        end

        // reset between an le pulse and its expected update
        step(1'b1, 6'b01_11_10, 2'd1, 1'b1, "rst_mid_load");
        step(1'b0, 6'b00_00_00, 2'd0, 1'b0, "rst_mid");
        step(1'b1, 6'b11_11_11, 2'd2, 1'b0, "post_rst");
        step(1'b1, 6'b11_11_11, 2'd2, 1'b0, "post_rst");
        step(1'b1, 6'b10_00_00, 2'd2, 1'b1, "post_rst_load");
        step(1'b1, 6'b00_00_00, 2'd0, 1'b0, "post_rst_idle");

        // random mix
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 6'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rand");
        end

        // drain the final vector
        step(1'b1, 6'd0, 2'd0, 1'b0, "drain");
        step(1'b1, 6'd0, 2'd0, 1'b0, "drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
